// File: rtl/fb_reg.sv
// Parallel-load register with synchronous clear: reset beats load, load beats hold.
// Q is driven only by the flops, so D, LD and RST have no combinational path to it.
module fb_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= RST_VAL;
    end else if (LD) begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_fb_reg.sv
// Directed bench for fb_reg: load, hold, synchronous reset, reset priority, release.
// Inputs change on falling edges (or mid-cycle); Q is sampled 1 time unit after a rising edge.
module tb_fb_reg;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [3:0] d;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  fb_reg #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .D  (d),
    .CLK(clk),
    .RST(rst),
    .LD (ld),
    .Q  (q)
  );

  // clock / reset block: period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge, then move to 1 unit after the next rising edge.
  task automatic step(input logic [3:0] dv, input logic ldv, input logic rstv);
    @(negedge clk);
    d   = dv;
    ld  = ldv;
    rst = rstv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    checks++;
    assert (q === exp)
    else begin
      errors++;
      $error("FAIL %s: q=%h expected %h", tag, q, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ld  = 1'b0;
    d   = 4'h0;

    // Initial reset: Q is not checked until this first reset edge has happened.
    step(4'h7, 1'b0, 1'b1);
    check("reset_init", 4'h0);

    // Test 1: loads, each visible one edge later.
    step(4'hF, 1'b1, 1'b0);
    check("load_f", 4'hF);
    step(4'hE, 1'b1, 1'b0);
    check("load_e", 4'hE);
    // D changes mid-cycle with LD high: Q must not follow until the edge.
    #3 d = 4'h3;
    #1 check("no_comb_d", 4'hE);

    // Test 2: reset with LD=0, then reset held for 5 edges while D (and LD) change.
    step(4'hE, 1'b0, 1'b1);
    check("reset_ld0", 4'h0);
    step(4'hD, 1'b0, 1'b1);
    check("reset_hold1", 4'h0);
    step(4'hC, 1'b1, 1'b1);
    check("reset_hold2", 4'h0);
    step(4'hD, 1'b0, 1'b1);
    check("reset_hold3", 4'h0);
    step(4'hC, 1'b1, 1'b1);
    check("reset_hold4", 4'h0);
    step(4'hC, 1'b0, 1'b1);
    check("reset_hold5", 4'h0);

    // Test 3: load B then hold across 3 edges while D changes.
    step(4'hB, 1'b1, 1'b0);
    check("load_b", 4'hB);
    step(4'h1, 1'b0, 1'b0);
    check("hold1", 4'hB);
    step(4'h6, 1'b0, 1'b0);
    check("hold2", 4'hB);
    step(4'hA, 1'b0, 1'b0);
    check("hold3", 4'hB);

    // Test 4: reset and load on the same edge, reset wins.
    step(4'h9, 1'b1, 1'b1);
    check("rst_over_ld", 4'h0);

    // Test 5a: RST pulses high and low entirely between two rising edges.
    step(4'h5, 1'b1, 1'b0);
    check("load_5", 4'h5);
    step(4'h5, 1'b0, 1'b0);
    check("hold_5", 4'h5);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check("rst_glitch", 4'h5);

    // Test 5b: RST rises mid-cycle; Q clears only at the next rising edge.
    #3 rst = 1'b1;
    #2 check("rst_mid_before", 4'h5);
    @(posedge clk);
    #1 check("rst_mid_after", 4'h0);

    // Test 6: release from reset, first LD edge loads; then all-zero data loads.
    step(4'hB, 1'b1, 1'b0);
    check("release_load_b", 4'hB);
    step(4'h0, 1'b1, 1'b0);
    check("load_zero", 4'h0);

    // Alternating bit patterns load whole-word.
    step(4'hA, 1'b1, 1'b0);
    check("load_a", 4'hA);
    step(4'h5, 1'b1, 1'b0);
    check("load_5_again", 4'h5);
    step(4'hF, 1'b0, 1'b0);
    check("hold_final", 4'h5);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
